rgb_window_gen: RTL
===================

RGB_WINDOW_GEN -- requirements
Module: rgb_window_gen

Interface
REQ-001 Parameter IMG_W, default 640: pixels per line, minimum 3.
REQ-002 Parameter IMG_H, default 480: lines per frame, minimum 3.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port pix_in, input, 24 bits: raster pixel, packed {R[23:16], G[15:8], B[7:0]}.
REQ-006 Port pix_valid, input, 1 bit: pix_in is valid this cycle.
REQ-007 Port pix_sof, input, 1 bit: the pixel offered this cycle is (row 0, col 0); qualified by pix_valid.
REQ-008 Port pix_ready, output, 1 bit: the block accepts pix_in this cycle.
REQ-009 Port RGB_window, output, 216 bits: 3x3 window, pixels a..i row-major; a occupies [215:192] and i occupies [23:0]; each pixel packed {R,G,B}.
REQ-010 Port win_valid, output, 1 bit: RGB_window is valid.
REQ-011 Port win_ready, input, 1 bit: the downstream consumer takes the window this cycle.
REQ-012 Port win_last, output, 1 bit: the current window is the last window of the frame; qualified by win_valid.

Function
REQ-013 A pixel is accepted when pix_valid && pix_ready; a window is consumed when win_valid && win_ready.
REQ-014 pix_ready = !win_valid || win_ready, evaluated combinationally (single output register, no skid buffer).
REQ-015 A column counter col (0..IMG_W-1) and a row counter row (0..IMG_H-1) track the position of the accepted pixel; both advance only on acceptance.
REQ-016 col wraps from IMG_W-1 to 0 and increments row; row wraps from IMG_H-1 to 0 at end of frame.
REQ-017 An accepted pixel with pix_sof=1 is treated as position (0,0) regardless of the counter values; the counters continue from (0,1).
REQ-018 Two line buffers, each IMG_W x 24 bits, hold rows row-1 and row-2.
REQ-019 On acceptance at column c: read both line buffers at c, move old row-1 data into the row-2 buffer at c, and write pix_in into the row-1 buffer at c.
REQ-020 Three 2-deep column shift registers, one per window row, hold columns c-1 and c-2; they shift only on acceptance.
REQ-021 Accepting the pixel at (r,c) with r>=2 and c>=2 loads RGB_window with the pixels at rows r-2..r and columns c-2..c, and sets win_valid on the next cycle (latency 1).
REQ-022 Accepted pixels with r<2 or c<2 produce no window; each frame yields exactly (IMG_W-2)*(IMG_H-2) windows.
REQ-023 win_last=1 exactly for the window whose i pixel is at (IMG_H-1, IMG_W-1).
REQ-024 win_valid clears on consumption unless a new window loads in the same cycle; in that case it stays high with the new data.
REQ-025 RGB_window and win_last hold stable while win_valid && !win_ready.
REQ-026 Line-buffer contents are not cleared at frame start; windows with r>=2 never read stale rows.

Reset
REQ-027 While rst_n=0: win_valid=0, win_last=0, RGB_window=0, col=0, row=0, column shift registers=0; pix_ready=1 as a consequence of REQ-014.
REQ-028 Reset asserted mid-frame discards the partial frame and any pending window; the first pixel accepted after release is treated as (0,0) even without pix_sof.
REQ-029 Line-buffer memories are not reset.

Structure
REQ-030 Shared package rgb_win_pkg holds PIX_W=24, WIN_PIX=9, WIN_W=216 and the window slice offsets used by the top-level consumer.
REQ-031 One sub-module, rgb_line_buffer (IMG_W x 24, one read and one write port at the same address, read-before-write), is instantiated twice.

Verification
REQ-032 IMG_W=5, IMG_H=4, no stalls, pixel at (r,c) = {r, c, 8'h5A}, sof on the first pixel -> 6 windows; the first appears the cycle after the 13th acceptance with a=24'h00005A and i=24'h02025A; win_last only on the 6th window, whose i=24'h03045A.
REQ-033 Same frame with win_ready held low for 4 cycles while a window is pending -> pix_ready=0 for those cycles, RGB_window stable, no window lost or duplicated.
REQ-034 pix_valid toggling 1,0,1,0 -> window contents identical to REQ-032; counters do not advance on idle cycles.
REQ-035 pix_sof reasserted at (2,1) of frame 1 -> counters restart; the next window is generated only after new row 2, col 2, with a taken from the new frame's (0,0).
REQ-036 rst_n pulsed low at (3,2) while win_valid=1 -> win_valid=0 immediately; the next frame without sof produces 6 correct windows.
REQ-037 Two back-to-back frames with win_ready=1 -> 12 windows; win_last on the 6th and 12th only.

Source files
------------

// File: rtl/rgb_win_pkg.sv
// Shared widths and window slice offsets for the 3x3 RGB window generator
// and for whatever consumes RGB_window downstream.
package rgb_win_pkg;

  localparam int PIX_W   = 24;
  localparam int WIN_PIX = 9;
  localparam int WIN_W   = PIX_W * WIN_PIX;

  // Pixels a..i are row-major; a sits in the top slice, i in the bottom one.
  localparam int OFF_A = 8 * PIX_W;
  localparam int OFF_B = 7 * PIX_W;
  localparam int OFF_C = 6 * PIX_W;
  localparam int OFF_D = 5 * PIX_W;
  localparam int OFF_E = 4 * PIX_W;
  localparam int OFF_F = 3 * PIX_W;
  localparam int OFF_G = 2 * PIX_W;
  localparam int OFF_H = 1 * PIX_W;
  localparam int OFF_I = 0;

  typedef logic [PIX_W-1:0] pix_t;

  // Two taps per window row: the pixels at columns c-1 and c-2.
  typedef struct packed {
    pix_t c1;
    pix_t c2;
  } col_taps_t;

  // Slice offset of window pixel idx (0 = a .. 8 = i).
  function automatic int win_off(input int idx);
    return (WIN_PIX - 1 - idx) * PIX_W;
  endfunction

endpackage

// File: rtl/rgb_line_buffer.sv
// One raster line of pixels: a single address shared by an asynchronous
// read and a clocked write, so a read in the write cycle returns old data.
module rgb_line_buffer #(
  parameter int DEPTH = 640,
  parameter int W     = 24,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  // Not reset: every location is rewritten before a window can use it.
  logic [W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/rgb_window_gen.sv
// Raster-scan 3x3 RGB window generator: two line buffers plus column taps
// produce one window per accepted pixel at row>=2, col>=2.
module rgb_window_gen
  import rgb_win_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  input  logic             pix_sof,
  output logic             pix_ready,
  output logic [WIN_W-1:0] RGB_window,
  output logic             win_valid,
  input  logic             win_ready,
  output logic             win_last
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // The window register is the only storage stage, so a new pixel may enter
  // only when that register is empty or being drained in the same cycle.

  logic [CW-1:0] col, eff_col, nxt_col;
  logic [RW-1:0] row, eff_row, nxt_row;
  logic          accept;
  logic          win_load;
  logic          last_pos;
  pix_t          lb1_rd, lb2_rd;
  col_taps_t     top_taps, mid_taps, bot_taps;

  assign pix_ready = !win_valid || win_ready;
  assign accept    = pix_valid && pix_ready;

  // A start-of-frame pixel overrides the counters and is placed at (0,0).
  always_comb begin
    eff_col = pix_sof ? '0 : col;
    eff_row = pix_sof ? '0 : row;
    nxt_col = eff_col + 1'b1;
    nxt_row = eff_row;
    if (eff_col == CW'(IMG_W - 1)) begin
      nxt_col = '0;
      nxt_row = (eff_row == RW'(IMG_H - 1)) ? '0 : eff_row + 1'b1;
    end
  end

  assign win_load = accept && (eff_row >= RW'(2)) && (eff_col >= CW'(2));
  assign last_pos = (eff_row == RW'(IMG_H - 1)) && (eff_col == CW'(IMG_W - 1));

  // lb1 holds row r-1, lb2 holds row r-2; lb2 is refilled with what lb1 held.
  rgb_line_buffer #(
    .DEPTH(IMG_W),
    .W    (PIX_W)
  ) u_lb1 (
    .clk  (clk),
    .we   (accept),
    .addr (eff_col),
    .wdata(pix_in),
    .rdata(lb1_rd)
  );

  rgb_line_buffer #(
    .DEPTH(IMG_W),
    .W    (PIX_W)
  ) u_lb2 (
    .clk  (clk),
    .we   (accept),
    .addr (eff_col),
    .wdata(lb1_rd),
    .rdata(lb2_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      top_taps   <= '0;
      mid_taps   <= '0;
      bot_taps   <= '0;
      win_valid  <= 1'b0;
      win_last   <= 1'b0;
      RGB_window <= '0;
    end else begin
      if (accept) begin
        col         <= nxt_col;
        row         <= nxt_row;
        top_taps.c2 <= top_taps.c1;
        top_taps.c1 <= lb2_rd;
        mid_taps.c2 <= mid_taps.c1;
        mid_taps.c1 <= lb1_rd;
        bot_taps.c2 <= bot_taps.c1;
        bot_taps.c1 <= pix_in;
      end
      if (win_load) begin
        win_valid                  <= 1'b1;
        win_last                   <= last_pos;
        RGB_window[OFF_A +: PIX_W] <= top_taps.c2;
        RGB_window[OFF_B +: PIX_W] <= top_taps.c1;
        RGB_window[OFF_C +: PIX_W] <= lb2_rd;
        RGB_window[OFF_D +: PIX_W] <= mid_taps.c2;
        RGB_window[OFF_E +: PIX_W] <= mid_taps.c1;
        RGB_window[OFF_F +: PIX_W] <= lb1_rd;
        RGB_window[OFF_G +: PIX_W] <= bot_taps.c2;
        RGB_window[OFF_H +: PIX_W] <= bot_taps.c1;
        RGB_window[OFF_I +: PIX_W] <= pix_in;
      end else if (win_ready) begin
        win_valid <= 1'b0;
        win_last  <= 1'b0;
      end
    end
  end

endmodule
